referee_1_rr: RTL and testbench
===============================

# referee_1_rr

Four-to-one round-robin referee for the transaction layer: drains four virtual-channel source FIFOs into a single destination FIFO, one 12-bit word per cycle. It is the mirror of the fan-out referee: it pops from whichever source is eligible in rotation, forwards the word one cycle later, and throttles on the destination's almost-full. It operates only while the link state machine reports IDLE or ACTIVE, and it reports idle back to that state machine.

## Interface
- LINE_SIZE, 12, word width
- NUM_VC, 4, number of source FIFOs; fixed at 4 in this revision
- clk  in  1  single clock; all state updates on rising edge
- reset_L  in  1  asynchronous, active-low reset
- state  in  4  link state, one-hot: RESET=0001, INIT=0010, IDLE=0100, ACTIVE=1000
- empty_f_signal  in  4  per-source FIFO empty
- almost_empty_signal  in  4  per-source FIFO holds at most 1 word
- almost_full_signal  in  1  destination almost-full; threshold leaves at least 2 free entries
- data_in  in  4*LINE_SIZE  source read data; source i occupies bits [i*12 +: 12], valid the cycle after its pop
- pop_signal  out  4  registered one-hot pop to source FIFOs
- push_signal  out  1  registered push to destination FIFO
- data_out  out  LINE_SIZE  registered word to destination
- idle_out  out  1  registered; no eligible source and nothing in flight

## Operation
- Enable: en = (state == IDLE) || (state == ACTIVE). Any other value, including an illegal encoding, clears en.
- Eligibility of source i: !empty_f_signal[i] && !(pop_signal[i] && almost_empty_signal[i]).
  - The second term blocks a second pop of a source whose last word is already in flight.
- Grant: when en && !almost_full_signal, pick the first eligible source, searching circularly from last_grant+1.
- Grant register update:
  - pop_signal <= one-hot(grant); last_grant <= grant.
  - With no grant, pop_signal <= 0 and last_grant holds.
- Forward stage:
  - push_signal <= |pop_signal.
  - data_out <= data_in slice selected by pop_signal. With no pop, data_out holds its last value.
- Idle: idle_out <= en && no eligible source && pop_signal == 0 && push_signal == 0.
- Leaving IDLE/ACTIVE: new pops stop immediately. A word already popped is still pushed on the following cycle.
- Reset values: pop_signal=0000, push_signal=0, data_out=0, idle_out=0, last_grant=3 (source 0 has first priority).

## Timing
- Cycle t: inputs are sampled and the grant is computed combinationally.
- Edge t+1: pop_signal[g] is high and the source FIFO performs the read.
- Edge t+2: push_signal=1 and data_out=data_in[g].
  - Pop-to-push latency is 1 cycle; sample-to-push latency is 2 cycles.
- Throughput:
  - 1 word/cycle sustained while any source stays eligible.
  - A single source with 1 word gets one pop, then waits for empty_f to update.
- almost_full_signal rising at t: no pop at t+1. At most one in-flight push, already covered by the 2-entry margin.
- Simultaneous requests: all four eligible at reset gives grants 0,1,2,3,0,... on consecutive cycles.
- Reset asserted mid-transfer: all outputs clear asynchronously and the in-flight word is dropped. Source FIFOs are reset by the same reset_L.
- Reset release: the first pop can occur on the first edge after reset_L rises, provided en is set.

## Structure
- Shared package referee_pkg:
  - LINE_SIZE, NUM_VC
  - state encodings ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE
  - these are reused by the fan-out referee and the state machine
- Sub-module rr_pick4: combinational circular priority picker.
  - Inputs: eligible[3:0], last_grant[1:0].
  - Outputs: grant_valid, grant[1:0].
- Top level holds the pop, push, data, idle and last_grant registers plus the data mux.

## Test plan
- Reset then ACTIVE, all four sources loaded (data 0x0A0, 0x0B1, 0x0C2, 0x0D3), almost_full=0 -> pop_signal 0001,0010,0100,1000 on consecutive cycles; push_signal high from the following cycle; data_out 0x0A0,0x0B1,0x0C2,0x0D3.
- Only source 2 holds one word 0x7FF -> exactly one pop (0100), one push with data_out=0x7FF, no second pop, idle_out=1 two cycles later.
- Streaming with almost_full_signal raised for 3 cycles -> pop stops the next cycle; the in-flight push still occurs; rotation resumes at last_grant+1 when it drops.
- state changes ACTIVE->INIT while pop_signal=0010 -> push occurs next cycle with that word; no further pops; idle_out=0 while disabled.
- reset_L pulsed low mid-stream -> pop_signal, push_signal, data_out, idle_out all 0 asynchronously; after release, first grant goes to source 0.

Source files
------------

// File: rtl/referee_1_rr_pkg.sv
// Shared definitions for the transaction-layer referees and the link state machine.
// Holds the word geometry, the one-hot link state encodings and small datapath helpers.
package referee_pkg;

    localparam int LINE_SIZE = 12;
    localparam int NUM_VC    = 4;

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } link_state_e;

    // Expands a 2-bit source index into a one-hot source select.
    function automatic logic [NUM_VC-1:0] onehot4(input logic [1:0] idx);
        logic [NUM_VC-1:0] vec;
        case (idx)
            2'd0:    vec = 4'b0001;
            2'd1:    vec = 4'b0010;
            2'd2:    vec = 4'b0100;
            2'd3:    vec = 4'b1000;
            default: vec = 4'b0000;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/referee_1_rr_if.sv
// Bundle between the fan-in referee, its four source FIFOs, the destination FIFO
// and the link state machine. master = referee side, slave = environment side.
interface referee_1_rr_if;
    import referee_pkg::*;

    logic [3:0]                  state;
    logic [NUM_VC-1:0]           empty_f_signal;
    logic [NUM_VC-1:0]           almost_empty_signal;
    logic                        almost_full_signal;
    logic [NUM_VC*LINE_SIZE-1:0] data_in;
    logic [NUM_VC-1:0]           pop_signal;
    logic                        push_signal;
    logic [LINE_SIZE-1:0]        data_out;
    logic                        idle_out;

    modport master (
        input  state, empty_f_signal, almost_empty_signal, almost_full_signal, data_in,
        output pop_signal, push_signal, data_out, idle_out
    );

    modport slave (
        output state, empty_f_signal, almost_empty_signal, almost_full_signal, data_in,
        input  pop_signal, push_signal, data_out, idle_out
    );

endinterface

// File: rtl/referee_1_rr_pick4.sv
// Combinational four-way circular priority picker: first eligible source found
// when searching upward from last_grant+1, wrapping modulo 4.
module rr_pick4 (
    input  logic [3:0] eligible,
    input  logic [1:0] last_grant,
    output logic       grant_valid,
    output logic [1:0] grant
);

    logic [1:0] idx_s;

    // Circular scan; the first hit wins and later offsets are ignored.
    always_comb begin
        grant_valid = 1'b0;
        grant       = 2'd0;
        idx_s       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx_s = last_grant + 2'(k);
            if (!grant_valid && eligible[idx_s]) begin
                grant_valid = 1'b1;
                grant       = idx_s;
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/referee_1_rr.sv
// Four-to-one round-robin fan-in referee: pops one eligible source per cycle and
// forwards the popped word to the destination FIFO one cycle later.
module referee_1_rr
    import referee_pkg::*;
(
    input  logic           clk,
    input  logic           reset_L,
    referee_1_rr_if.master bus
);

    logic                 en_s;
    logic [NUM_VC-1:0]    eligible_s;
    logic                 grant_valid_s;
    logic [1:0]           grant_s;
    logic                 take_s;
    logic [LINE_SIZE-1:0] fwd_word_s;

    logic [NUM_VC-1:0]    pop_r;
    logic                 push_r;
    logic [LINE_SIZE-1:0] data_out_r;
    logic                 idle_r;
    logic [1:0]           last_grant_r;

    // A source whose last word is already being popped must not be popped again.
    always_comb begin
        en_s       = (bus.state == ST_IDLE) || (bus.state == ST_ACTIVE);
        eligible_s = ~bus.empty_f_signal & ~(pop_r & bus.almost_empty_signal);
        take_s     = en_s && !bus.almost_full_signal && grant_valid_s;
    end

    rr_pick4 u_pick (
        .eligible    (eligible_s),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant       (grant_s)
    );

    // Selects the word of the source popped last cycle; holds otherwise.
    always_comb begin
        fwd_word_s = data_out_r;
        case (pop_r)
            4'b0001: fwd_word_s = bus.data_in[0*LINE_SIZE +: LINE_SIZE];
            4'b0010: fwd_word_s = bus.data_in[1*LINE_SIZE +: LINE_SIZE];
            4'b0100: fwd_word_s = bus.data_in[2*LINE_SIZE +: LINE_SIZE];
            4'b1000: fwd_word_s = bus.data_in[3*LINE_SIZE +: LINE_SIZE];
            default: fwd_word_s = data_out_r;
        endcase
    end

    // Grant, forward and idle registers; last_grant resets to 3 so source 0 goes first.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pop_r        <= 4'b0000;
            push_r       <= 1'b0;
            data_out_r   <= '0;
            idle_r       <= 1'b0;
            last_grant_r <= 2'd3;
        end else begin
            if (take_s) begin
                pop_r        <= onehot4(grant_s);
                last_grant_r <= grant_s;
            end else begin
                pop_r        <= 4'b0000;
                last_grant_r <= last_grant_r;
            end
            push_r     <= |pop_r;
            data_out_r <= fwd_word_s;
            idle_r     <= en_s && (eligible_s == 4'b0000) && (pop_r == 4'b0000) && !push_r;
        end
    end

    assign bus.pop_signal  = pop_r;
    assign bus.push_signal = push_r;
    assign bus.data_out    = data_out_r;
    assign bus.idle_out    = idle_r;

endmodule

// File: tb/tb_referee_1_rr.sv
// Directed bench for referee_1_rr with show-ahead source FIFO models and a
// scoreboard of popped words checked against each destination push.
module tb_referee_1_rr;
    import referee_pkg::*;

    logic clk;
    logic reset_L;

    referee_1_rr_if bus ();

    referee_1_rr dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source FIFO models: mem written by the stimulus, read pointer advanced on pop.
    logic [11:0] mem [4][64];
    int          wr  [4];
    int          rd  [4];

    logic [3:0]  empty_v;
    logic [3:0]  ae_v;
    logic [47:0] din_v;

    always_comb begin
        empty_v = 4'b0000;
        ae_v    = 4'b0000;
        din_v   = '0;
        for (int i = 0; i < 4; i++) begin
            empty_v[i]        = (wr[i] == rd[i]);
            ae_v[i]           = ((wr[i] - rd[i]) <= 1);
            din_v[i*12 +: 12] = mem[i][rd[i] % 64];
        end
    end

    assign bus.empty_f_signal      = empty_v;
    assign bus.almost_empty_signal = ae_v;
    assign bus.data_in             = din_v;

    always @(posedge clk or negedge reset_L) begin
        for (int i = 0; i < 4; i++) begin
            if (!reset_L)                 rd[i] <= wr[i];
            else if (bus.pop_signal[i])   rd[i] <= rd[i] + 1;
        end
    end

    int          n_tests;
    int          n_fail;
    logic [11:0] exp_q [$];
    logic [3:0]  prev_pop;
    logic [11:0] exp_w;
    logic [3:0]  exp_pops [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic load(input int s, input logic [11:0] d);
        mem[s][wr[s]] = d;
        wr[s] = wr[s] + 1;
    endtask

    // One clock: check push timing and scoreboard data, then record any new pop.
    task automatic step();
        @(posedge clk);
        #1;
        chk("push_timing", 32'(bus.push_signal), 32'(prev_pop != 4'b0000));
        chk("pop_onehot", 32'($countones(bus.pop_signal) <= 1), 32'd1);
        if (bus.push_signal === 1'b1) begin
            if (exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                chk("sb_data", 32'(bus.data_out), 32'(exp_w));
            end else begin
                chk("sb_underflow", 32'(exp_q.size()), 32'd1);
            end
        end
        for (int s = 0; s < 4; s++) begin
            if (bus.pop_signal[s]) exp_q.push_back(mem[s][rd[s] % 64]);
        end
        prev_pop = bus.pop_signal;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        prev_pop = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            wr[i] = 0;
            for (int j = 0; j < 64; j++) mem[i][j] = 12'h000;
        end
        reset_L                = 1'b0;
        bus.state              = ST_ACTIVE;
        bus.almost_full_signal = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pop",  32'(bus.pop_signal),  32'd0);
        chk("rst_push", 32'(bus.push_signal), 32'd0);
        chk("rst_data", 32'(bus.data_out),    32'd0);
        chk("rst_idle", 32'(bus.idle_out),    32'd0);

        // All four sources loaded: rotation 0,1,2,3 from reset
        @(negedge clk);
        reset_L = 1'b1;
        load(0, 12'h0A0); load(1, 12'h0B1); load(2, 12'h0C2); load(3, 12'h0D3);
        step(); chk("t1_pop0", 32'(bus.pop_signal), 32'b0001);
        step(); chk("t1_pop1", 32'(bus.pop_signal), 32'b0010);
        chk("t1_data0", 32'(bus.data_out), 32'h0A0);
        step(); chk("t1_pop2", 32'(bus.pop_signal), 32'b0100);
        chk("t1_data1", 32'(bus.data_out), 32'h0B1);
        step(); chk("t1_pop3", 32'(bus.pop_signal), 32'b1000);
        chk("t1_data2", 32'(bus.data_out), 32'h0C2);
        step(); chk("t1_pop4", 32'(bus.pop_signal), 32'b0000);
        chk("t1_data3", 32'(bus.data_out), 32'h0D3);
        step(); chk("t1_idle_early", 32'(bus.idle_out), 32'd0);
        step(); chk("t1_idle", 32'(bus.idle_out), 32'd1);

        // Single word in source 2: one pop, one push, then idle
        load(2, 12'h7FF);
        step(); chk("t2_pop", 32'(bus.pop_signal), 32'b0100);
        chk("t2_idle_busy", 32'(bus.idle_out), 32'd0);
        step(); chk("t2_no_repop", 32'(bus.pop_signal), 32'b0000);
        chk("t2_push", 32'(bus.push_signal), 32'd1);
        chk("t2_data", 32'(bus.data_out), 32'h7FF);
        step(); chk("t2_idle_wait", 32'(bus.idle_out), 32'd0);
        chk("t2_pop_quiet", 32'(bus.pop_signal), 32'b0000);
        step(); chk("t2_idle", 32'(bus.idle_out), 32'd1);

        // Streaming with almost_full for 3 cycles; rotation resumes after last grant
        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < 4; s++) load(s, 12'(12'h300 + 12'(s * 16) + 12'(k)));
        end
        exp_pops = '{4'b1000, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000,
                     4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0000};
        for (int n = 0; n < 16; n++) begin
            step();
            chk($sformatf("t3_pop%0d", n), 32'(bus.pop_signal), 32'(exp_pops[n]));
            if (n == 2) bus.almost_full_signal = 1'b1;
            if (n == 5) bus.almost_full_signal = 1'b0;
        end
        step();

        // ACTIVE -> INIT with source 1 popped: word still pushed, then no pops
        load(1, 12'h511); load(1, 12'h512); load(2, 12'h621); load(2, 12'h622);
        step(); chk("t4_pop", 32'(bus.pop_signal), 32'b0010);
        bus.state = ST_INIT;
        step(); chk("t4_stop", 32'(bus.pop_signal), 32'b0000);
        chk("t4_push", 32'(bus.push_signal), 32'd1);
        chk("t4_data", 32'(bus.data_out), 32'h511);
        step(); chk("t4_idle_dis", 32'(bus.idle_out), 32'd0);
        chk("t4_no_pop", 32'(bus.pop_signal), 32'b0000);
        step(); chk("t4_idle_dis2", 32'(bus.idle_out), 32'd0);
        bus.state = ST_ACTIVE;
        step(); chk("t4_resume", 32'(bus.pop_signal), 32'b0100);
        step(); chk("t4_resume2", 32'(bus.pop_signal), 32'b0010);

        // Asynchronous reset mid-stream drops the in-flight word
        reset_L = 1'b0;
        #1;
        chk("t5_pop",  32'(bus.pop_signal),  32'd0);
        chk("t5_push", 32'(bus.push_signal), 32'd0);
        chk("t5_data", 32'(bus.data_out),    32'd0);
        chk("t5_idle", 32'(bus.idle_out),    32'd0);
        exp_q.delete();
        prev_pop = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_L   = 1'b1;
        bus.state = 4'b1100;
        load(0, 12'h901); load(1, 12'h902); load(2, 12'h903); load(3, 12'h904);
        step(); chk("t5_illegal_pop", 32'(bus.pop_signal), 32'b0000);
        chk("t5_illegal_idle", 32'(bus.idle_out), 32'd0);
        bus.state = ST_ACTIVE;
        step(); chk("t5_first", 32'(bus.pop_signal), 32'b0001);
        step(); chk("t5_second", 32'(bus.pop_signal), 32'b0010);
        chk("t5_data", 32'(bus.data_out), 32'h901);
        repeat (4) step();
        chk("t5_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
